// File: rtl/noc_pkg.sv
// Shared NoC definitions: router address type and N/E/S/W direction encodings,
// used by the packet injector and the per-port header detector.
package noc_pkg;

    localparam int ADDR_WIDTH = 2;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t DIR_N = 2'b00;
    localparam addr_t DIR_E = 2'b01;
    localparam addr_t DIR_S = 2'b10;
    localparam addr_t DIR_W = 2'b11;

    // Flit index counter width; a single-flit packet still needs one bit.
    function automatic int idx_width(input int num_flits);
        if (num_flits > 1) begin
            return $clog2(num_flits);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/packet_injector_flit_serializer.sv
// Holds one packet payload and walks a flit index across it, presenting the
// current flit slice and a flag marking the final flit.
module flit_serializer
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 8,
    parameter int NUM_FLITS  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic                            advance,
    input  logic [FLIT_WIDTH*NUM_FLITS-1:0] payload,
    output logic [FLIT_WIDTH-1:0]           flit_data,
    output logic                            flit_last
);

    localparam int                IDX_W    = idx_width(NUM_FLITS);
    localparam int                PAY_W    = FLIT_WIDTH * NUM_FLITS;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FLITS - 1);

    logic [PAY_W-1:0] payload_q, payload_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign flit_last = (idx_q == LAST_IDX);
    assign flit_data = payload_q[FLIT_WIDTH*int'(idx_q) +: FLIT_WIDTH];

    // Next payload/index: capture on load, step on each accepted flit.
    always_comb begin
        payload_d = payload_q;
        idx_d     = idx_q;
        if (load) begin
            payload_d = payload;
            idx_d     = {IDX_W{1'b0}};
        end else if (advance) begin
            if (flit_last) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Payload and index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            payload_q <= {PAY_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
        end else begin
            payload_q <= payload_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: rtl/packet_injector.sv
// Accepts packet descriptors and drives their flits onto one router input link,
// holding the destination header; packets for the local router are dropped.
module packet_injector
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 8,
    parameter int NUM_FLITS  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_WIDTH-1:0]           local_addr,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ADDR_WIDTH-1:0]           in_dest,
    input  logic [FLIT_WIDTH*NUM_FLITS-1:0] in_payload,
    output logic                            link_valid,
    input  logic                            link_ready,
    output logic [ADDR_WIDTH-1:0]           link_header,
    output logic [FLIT_WIDTH-1:0]           link_data,
    output logic                            link_last,
    output logic                            self_drop,
    output logic [CNT_WIDTH-1:0]            pkt_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    state_e                state_q, state_d;
    addr_t                 dest_q, dest_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic                  self_drop_q, self_drop_d;
    logic                  load_s;
    logic                  advance_s;
    logic                  flit_last_s;

    flit_serializer #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .NUM_FLITS  (NUM_FLITS)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .advance   (advance_s),
        .payload   (in_payload),
        .flit_data (link_data),
        .flit_last (flit_last_s)
    );

    // Link-side outputs decode only from registers, so link_ready never reaches in_ready.
    assign in_ready    = (state_q == S_IDLE);
    assign link_valid  = (state_q == S_SEND);
    assign link_last   = (state_q == S_SEND) && flit_last_s;
    assign link_header = dest_q;
    assign self_drop   = self_drop_q;
    assign pkt_count   = pkt_count_q;

    // Next-state logic: descriptor intake in IDLE, flit handshakes in SEND.
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        pkt_count_d = pkt_count_q;
        self_drop_d = 1'b0;
        load_s      = 1'b0;
        advance_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_dest == local_addr) begin
                        self_drop_d = 1'b1;
                    end else begin
                        dest_d  = in_dest;
                        load_s  = 1'b1;
                        state_d = S_SEND;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (link_ready) begin
                    advance_s = 1'b1;
                    if (flit_last_s) begin
                        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dest_q      <= DIR_N;
            pkt_count_q <= {CNT_WIDTH{1'b0}};
            self_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            pkt_count_q <= pkt_count_d;
            self_drop_q <= self_drop_d;
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Randomized and directed bench for packet_injector, checked against a
// queue-of-flits reference model of the injector's externally visible behaviour.
module tb_packet_injector;

    localparam int FW    = 8;
    localparam int NF    = 4;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        local_addr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_dest;
    logic [FW*NF-1:0]  in_payload;
    logic              link_valid;
    logic              link_ready;
    logic [1:0]        link_header;
    logic [FW-1:0]     link_data;
    logic              link_last;
    logic              self_drop;
    logic [CNT_W-1:0]  pkt_count;

    packet_injector #(
        .FLIT_WIDTH (FW),
        .NUM_FLITS  (NF),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .local_addr  (local_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dest     (in_dest),
        .in_payload  (in_payload),
        .link_valid  (link_valid),
        .link_ready  (link_ready),
        .link_header (link_header),
        .link_data   (link_data),
        .link_last   (link_last),
        .self_drop   (self_drop),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    hdr;
        logic [FW-1:0] data;
        logic          last;
    } flit_t;

    flit_t            m_q[$];
    logic [CNT_W-1:0] m_cnt;
    logic             m_drop;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare the current outputs with the model, apply inputs, advance model and clock.
    task automatic step(input logic rst, input logic v, input logic [1:0] d,
                        input logic [FW*NF-1:0] p, input logic rdy);
        flit_t f;
        logic  nxt_drop;
        check_eq("in_ready",   in_ready,   m_q.size() == 0);
        check_eq("link_valid", link_valid, m_q.size() != 0);
        check_eq("self_drop",  self_drop,  m_drop);
        check_eq("pkt_count",  pkt_count,  m_cnt);
        if (m_q.size() != 0) begin
            check_eq("link_header", link_header, m_q[0].hdr);
            check_eq("link_data",   link_data,   m_q[0].data);
            check_eq("link_last",   link_last,   m_q[0].last);
        end else begin
            check_eq("link_last_idle", link_last, 1'b0);
        end
        rst_n      = rst;
        in_valid   = v;
        in_dest    = d;
        in_payload = p;
        link_ready = rdy;
        if (!rst) begin
            m_q.delete();
            m_cnt  = '0;
            m_drop = 1'b0;
        end else begin
            nxt_drop = 1'b0;
            if (m_q.size() == 0) begin
                if (v && d == local_addr) begin
                    nxt_drop = 1'b1;
                end else if (v) begin
                    for (int i = 0; i < NF; i++) begin
                        f.hdr  = d;
                        f.data = p[i*FW +: FW];
                        f.last = (i == NF - 1);
                        m_q.push_back(f);
                    end
                end
            end else if (rdy) begin
                f = m_q.pop_front();
                if (f.last) m_cnt = m_cnt + 1'b1;
            end
            m_drop = nxt_drop;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, '0, rdy);
    endtask

    logic [CNT_W-1:0] wrap_exp [5];
    logic [1:0]       rd;

    initial begin
        rst_n      = 1'b0;
        local_addr = 2'b00;
        in_valid   = 1'b0;
        in_dest    = 2'b00;
        in_payload = '0;
        link_ready = 1'b0;
        m_cnt      = '0;
        m_drop     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_link_valid",  link_valid,  1'b0);
        check_eq("rst_link_last",   link_last,   1'b0);
        check_eq("rst_link_header", link_header, 2'b00);
        check_eq("rst_link_data",   link_data,   8'h00);
        check_eq("rst_self_drop",   self_drop,   1'b0);
        check_eq("rst_pkt_count",   pkt_count,   2'd0);
        check_eq("rst_in_ready",    in_ready,    1'b1);
        idle(1, 1'b1);

        // Straight packet: AA, BB, CC, DD with header E.
        local_addr = 2'b00;
        step(1'b1, 1'b1, 2'b01, 32'hDDCCBBAA, 1'b1);
        check_eq("t1_flit0", link_data, 8'hAA);
        idle(4, 1'b1);
        check_eq("t1_count", pkt_count, 2'd1);
        idle(1, 1'b1);

        // Same packet, flit 1 stalled for three cycles.
        step(1'b1, 1'b1, 2'b01, 32'hDDCCBBAA, 1'b1);
        idle(1, 1'b1);
        idle(3, 1'b0);
        check_eq("t2_held", link_data, 8'hBB);
        idle(4, 1'b1);

        // Descriptor addressed to ourselves.
        local_addr = 2'b10;
        step(1'b1, 1'b1, 2'b10, 32'h12345678, 1'b1);
        check_eq("t3_drop", self_drop, 1'b1);
        idle(2, 1'b1);

        // in_valid held high, payload and dest changing every cycle.
        for (int i = 0; i < 12; i++) begin
            rd = 2'($urandom_range(0, 3));
            if (rd == local_addr) rd = 2'b01;
            step(1'b1, 1'b1, rd, $urandom, 1'b1);
        end
        idle(6, 1'b1);

        // Reset after the first flit, then a fresh packet.
        step(1'b1, 1'b1, 2'b11, 32'h44332211, 1'b1);
        idle(1, 1'b1);
        step(1'b0, 1'b0, 2'b00, '0, 1'b1);
        check_eq("t5_valid_after_rst", link_valid, 1'b0);
        check_eq("t5_count_after_rst", pkt_count, 2'd0);
        step(1'b1, 1'b1, 2'b01, 32'h88776655, 1'b1);
        check_eq("t5_first_flit", link_data, 8'h55);
        idle(5, 1'b1);

        // Counter wrap with a 2-bit count.
        step(1'b0, 1'b0, 2'b00, '0, 1'b1);
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 2'b00, $urandom, 1'b1);
            idle(4, 1'b1);
            check_eq("t6_wrap", pkt_count, wrap_exp[k]);
        end

        // Random traffic with occasional resets and local address changes.
        for (int i = 0; i < 400; i++) begin
            if (m_q.size() == 0 && $urandom_range(0, 19) == 0)
                local_addr = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1),
                 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 9) < 7));
        end
        idle(8, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_injector.md
# packet_injector

Transmit-side counterpart of the router's per-port header detector. Accepts one packet descriptor (2-bit destination address + payload), splits the payload into flits, and drives them onto one router input link. The 2-bit destination header is held on the link for every flit so the downstream detector can match it against its router address. Packets addressed to the local router are dropped, never injected.

## Interface
Parameters:
- FLIT_WIDTH, 8, data bits per flit
- NUM_FLITS, 4, flits per packet (≥1); payload width = FLIT_WIDTH*NUM_FLITS
- CNT_WIDTH, 8, width of the sent-packet counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- local_addr  in  2  this router's address (N/S/E/W encoding); quasi-static
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_dest  in  2  destination router address
- in_payload  in  FLIT_WIDTH*NUM_FLITS  payload; flit 0 = bits [FLIT_WIDTH-1:0]
- link_valid  out  1  flit valid on link
- link_ready  in  1  downstream accepts flit when link_valid & link_ready
- link_header  out  2  destination header, constant for a packet
- link_data  out  FLIT_WIDTH  current flit
- link_last  out  1  final flit of packet
- self_drop  out  1  one-cycle pulse: accepted descriptor had in_dest == local_addr
- pkt_count  out  CNT_WIDTH  packets fully injected since reset, wraps

## Operation
- Two-state FSM: IDLE, SEND.
- IDLE: in_ready=1, link_valid=0. On in_valid:
  - in_dest == local_addr: descriptor consumed, self_drop=1 next cycle, stay IDLE, nothing on link.
  - otherwise: register in_dest and in_payload, flit index idx=0, go SEND.
- SEND: in_ready=0, link_valid=1, link_header=registered dest, link_data=payload slice idx, link_last=(idx==NUM_FLITS-1).
  - link_ready=0: all link outputs held stable.
  - link_ready=1 & !link_last: idx+1.
  - link_ready=1 & link_last: pkt_count+1 (wraps 2^CNT_WIDTH-1 → 0), go IDLE.
- in_payload/in_dest changes after acceptance have no effect on the packet in flight.
- idx counter width = clog2(NUM_FLITS) (min 1); NUM_FLITS=1 → every flit is link_last.
- Never asserts link_valid without a registered non-local destination.

## Timing
- Reset (rst_n=0 at a clk edge): state=IDLE, idx=0, link_valid=0, link_last=0, link_header=0, link_data=0, self_drop=0, pkt_count=0; in_ready=1 from the first cycle after reset release.
- Reset mid-packet: remaining flits abandoned, no link_last issued, pkt_count cleared; link_valid=0 the cycle after the reset edge.
- Acceptance at edge T → first flit valid in cycle T+1 (one-cycle latency).
- With link_ready held high, a packet occupies NUM_FLITS cycles on the link followed by ≥1 IDLE cycle; max throughput one packet per NUM_FLITS+1 cycles.
- self_drop asserted exactly the one cycle after the dropped descriptor's acceptance edge.
- in_ready depends only on state (registered); no combinational path link_ready → in_ready.
- pkt_count updates on the edge where the last flit is accepted.

## Structure
- Shared package noc_pkg: ADDR_WIDTH=2, typedef addr_t, direction constants DIR_N=2'b00, DIR_E=2'b01, DIR_S=2'b10, DIR_W=2'b11; used by this block and the detector.
- FSM state enum local to this block.
- One natural sub-module: flit_serializer (payload register + idx counter + slice mux + last flag), with the FSM, self-drop check and pkt_count in packet_injector.

## Test plan
- Reset then local_addr=DIR_N, in_dest=DIR_E, payload 32'hDDCCBBAA, link_ready=1 → flits AA,BB,CC,DD on consecutive cycles, link_header=2'b01 throughout, link_last only on DD, pkt_count=1.
- Same packet with link_ready low for 3 cycles on flit 1 → BB and header held stable 3 cycles; no flit lost or duplicated.
- in_dest == local_addr=DIR_S (2'b10) → self_drop one cycle, link_valid stays 0, pkt_count unchanged, in_ready stays 1.
- Back-to-back descriptors with in_valid held high → exactly one IDLE cycle between packets; second packet's header correct; in_payload changes mid-packet do not alter flits.
- rst_n=0 after flit 1 of 4 → link_valid=0 next cycle, no link_last, pkt_count=0; new packet after release is sent from flit 0.
- CNT_WIDTH=2, inject 5 packets → pkt_count 1,2,3,0,1.
